// File: rtl/pixel_packer.sv
// Packs a 24-bit pixel stream into 16-bit RAM words: header (width, height), then 3 words per pixel pair.
// Optional PACKER_CHECKSUM_EN appends a mod-2^16 sum of all written words at the end of the frame.
module pixel_packer #(
    parameter int unsigned ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       width,
    input  logic [15:0]       height,
    input  logic [23:0]       pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic [ADDR_W-1:0] w_addr,
    output logic [15:0]       wdata,
    output logic              wr_en,
    output logic              busy,
    output logic              done
);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR_W, S_HDR_H, S_PA, S_PB, S_W2, S_PAD, S_CSUM, S_FIN
    } state_t;

    state_t      r_state;
    state_t      w_end_state;
    logic [15:0] r_width;
    logic [15:0] r_height;
    logic [31:0] r_cnt;
    logic [7:0]  r_pa_hi;
    logic [15:0] r_pb_hi;
    logic [31:0] w_n;
    logic [31:0] w_cnt_inc;
    logic        w_xfer;
    logic        w_we;
    logic [15:0] w_wd;

`ifdef PACKER_CHECKSUM_EN
    logic [15:0] r_sum;
    assign w_end_state = S_CSUM;
`else
    assign w_end_state = S_FIN;
`endif

    assign w_n       = 32'(r_width) * 32'(r_height);
    assign w_cnt_inc = 32'(r_cnt + 32'd1);
    assign pix_ready = (r_state == S_PA) || (r_state == S_PB);
    assign busy      = (r_state != S_IDLE);
    assign w_xfer    = pix_valid & pix_ready;

    // Word to be written at the coming edge, decoded from the current state
    always_comb begin
        w_we = 1'b0;
        w_wd = 16'h0000;
        case (r_state)
            S_HDR_W: begin w_we = 1'b1;   w_wd = r_width; end
            S_HDR_H: begin w_we = 1'b1;   w_wd = r_height; end
            S_PA:    begin w_we = w_xfer; w_wd = pix_in[15:0]; end
            S_PB:    begin w_we = w_xfer; w_wd = {pix_in[7:0], r_pa_hi}; end
            S_W2:    begin w_we = 1'b1;   w_wd = r_pb_hi; end
            S_PAD:   begin w_we = 1'b1;   w_wd = {8'h00, r_pa_hi}; end
`ifdef PACKER_CHECKSUM_EN
            S_CSUM:  begin w_we = 1'b1;   w_wd = r_sum; end
`endif
            default: begin w_we = 1'b0;   w_wd = 16'h0000; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_width  <= 16'h0000;
            r_height <= 16'h0000;
            r_cnt    <= 32'd0;
            r_pa_hi  <= 8'h00;
            r_pb_hi  <= 16'h0000;
            w_addr   <= '0;
            wdata    <= 16'h0000;
            wr_en    <= 1'b0;
            done     <= 1'b0;
        end else begin
            wr_en <= w_we;
            if (w_we) begin
                wdata <= w_wd;
            end
            done <= (r_state == S_FIN);
            // Address advances in the cycle after each write so back-to-back writes stay contiguous
            if (r_state == S_IDLE && start) begin
                w_addr <= '0;
            end else if (wr_en) begin
                w_addr <= w_addr + ADDR_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_width  <= width;
                        r_height <= height;
                        r_cnt    <= 32'd0;
                        r_state  <= S_HDR_W;
                    end
                end
                S_HDR_W: r_state <= S_HDR_H;
                S_HDR_H: r_state <= (w_n != 32'd0) ? S_PA : w_end_state;
                S_PA: begin
                    if (w_xfer) begin
                        r_pa_hi <= pix_in[23:16];
                        r_cnt   <= w_cnt_inc;
                        r_state <= (w_cnt_inc == w_n) ? S_PAD : S_PB;
                    end
                end
                S_PB: begin
                    if (w_xfer) begin
                        r_pb_hi <= pix_in[23:8];
                        r_cnt   <= w_cnt_inc;
                        r_state <= S_W2;
                    end
                end
                S_W2:    r_state <= (r_cnt == w_n) ? w_end_state : S_PA;
                S_PAD:   r_state <= w_end_state;
                S_CSUM:  r_state <= S_FIN;
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef PACKER_CHECKSUM_EN
    // Running sum of every word issued, cleared when a frame is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= 16'h0000;
        end else if (r_state == S_IDLE && start) begin
            r_sum <= 16'h0000;
        end else if (w_we) begin
            r_sum <= 16'(r_sum + w_wd);
        end
    end
`endif

endmodule

// File: tb/tb_pixel_packer.sv
// Randomized bench for pixel_packer: a word-list model built from the packing rules is compared
// against every RAM write, plus literal anchors for the model and reset behaviour.
module tb_pixel_packer;

    localparam int unsigned ADDR_W = 18;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [15:0]       width;
    logic [15:0]       height;
    logic [23:0]       pix_in;
    logic              pix_valid;
    logic              pix_ready;
    logic [ADDR_W-1:0] w_addr;
    logic [15:0]       wdata;
    logic              wr_en;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    pixel_packer #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .width(width), .height(height),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .w_addr(w_addr), .wdata(wdata), .wr_en(wr_en), .busy(busy), .done(done)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    int          idx;
    int          done_cnt;
    bit          prev_wr;
    bit          ready_seen;
    bit          mon_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected word list for a frame, straight from the packing layout
    task automatic build_model(input logic [15:0] w, input logic [15:0] h, input logic [23:0] px[$]);
        int unsigned sum;
        exp_q.delete();
        exp_q.push_back(w);
        exp_q.push_back(h);
        for (int i = 0; i < px.size(); i += 2) begin
            if (i + 1 < px.size()) begin
                exp_q.push_back(px[i][15:0]);
                exp_q.push_back({px[i+1][7:0], px[i][23:16]});
                exp_q.push_back(px[i+1][23:8]);
            end else begin
                exp_q.push_back(px[i][15:0]);
                exp_q.push_back({8'h00, px[i][23:16]});
            end
        end
`ifdef PACKER_CHECKSUM_EN
        sum = 0;
        foreach (exp_q[j]) sum += 32'(exp_q[j]);
        exp_q.push_back(16'(sum));
`else
        sum = 0;
`endif
    endtask

    // One cycle: wait for the falling edge and compare whatever the DUT presented
    task automatic tick();
        @(negedge clk);
        if (mon_en) begin
            if (wr_en) begin
                if (idx < exp_q.size()) begin
                    check("wr_addr", 32'(w_addr), 32'(idx));
                    check("wr_data", 32'(wdata), 32'(exp_q[idx]));
                end else begin
                    check("extra_write", 32'(w_addr), 32'hFFFF_FFFF);
                end
                idx++;
            end
            if (done) begin
                done_cnt++;
                check("done_timing", {29'd0, (idx == exp_q.size()), prev_wr, busy}, 32'd6);
            end
            if (pix_ready) ready_seen = 1'b1;
            prev_wr = wr_en;
        end
    endtask

    task automatic begin_frame(input logic [15:0] w, input logic [15:0] h, input logic [23:0] px[$]);
        build_model(w, h, px);
        idx = 0; done_cnt = 0; prev_wr = 1'b0; ready_seen = 1'b0; mon_en = 1'b1;
        width = w; height = h; start = 1'b1;
        tick();
        start = 1'b0;
        width = 16'($urandom); height = 16'($urandom);
    endtask

    // Feed pixels until `limit` accepted; returns the count accepted
    task automatic feed(input logic [23:0] px[$], input int limit, input int vprob,
                        input bit extra_start, output int k);
        int cyc;
        k = 0; cyc = 0;
        while (k < limit && cyc < 2000) begin
            pix_valid = ($urandom_range(99) < vprob);
            pix_in    = pix_valid ? px[k] : 24'($urandom);
            start     = (extra_start && cyc == 3);
            if (pix_valid && pix_ready) k++;
            tick();
            cyc++;
        end
        pix_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] w, input logic [15:0] h, input logic [23:0] px[$],
                             input int vprob, input bit extra_start);
        int k;
        int cyc;
        begin_frame(w, h, px);
        feed(px, px.size(), vprob, extra_start, k);
        check("pixels_taken", 32'(k), 32'(px.size()));
        cyc = 0;
        while (done_cnt == 0 && cyc < 100) begin
            tick();
            cyc++;
        end
        tick();
        tick();
        check("done_count", 32'(done_cnt), 32'd1);
        check("write_count", 32'(idx), 32'(exp_q.size()));
        check("final_addr", 32'(w_addr), 32'(exp_q.size()));
        check("busy_after", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  32'(w_addr), 32'd0);
        check({tag, "_ctrl"},  {27'd0, wr_en, pix_ready, busy, done, 1'b0}, 32'd0);
        check({tag, "_wdata"}, 32'(wdata), 32'd0);
    endtask

    initial begin
        logic [23:0] px[$];
        logic [23:0] t1[$];
        logic [15:0] w;
        logic [15:0] h;
        int          k;

        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_in = '0;
        width = '0; height = '0; mon_en = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // T1: two pixels, model anchored to hand-computed words
        t1 = '{24'hAABBCC, 24'h112233};
        build_model(16'd2, 16'd1, t1);
        check("model_t1_w2", 32'(exp_q[2]), 32'h0000_BBCC);
        check("model_t1_w3", 32'(exp_q[3]), 32'h0000_33AA);
        check("model_t1_w4", 32'(exp_q[4]), 32'h0000_1122);
`ifdef PACKER_CHECKSUM_EN
        check("model_t1_sum", 32'(exp_q[5]), 32'h0000_009B);
        check("model_t1_len", 32'(exp_q.size()), 32'd6);
`else
        check("model_t1_len", 32'(exp_q.size()), 32'd5);
`endif
        run_frame(16'd2, 16'd1, t1, 100, 1'b0);
`ifdef PACKER_CHECKSUM_EN
        check("t1_end_addr", 32'(w_addr), 32'd6);
`else
        check("t1_end_addr", 32'(w_addr), 32'd5);
`endif

        // T2: odd pixel count pads the last word
        px = '{24'hAABBCC, 24'h112233, 24'h445566};
        build_model(16'd3, 16'd1, px);
        check("model_t2_w5", 32'(exp_q[5]), 32'h0000_5566);
        check("model_t2_w6", 32'(exp_q[6]), 32'h0000_0044);
        run_frame(16'd3, 16'd1, px, 100, 1'b0);

        // T3: empty frame writes only the header
        px.delete();
        run_frame(16'd0, 16'd5, px, 100, 1'b0);
        check("t3_no_ready", {31'd0, ready_seen}, 32'd0);

        // T4: stalls plus a stray start mid-frame
        run_frame(16'd2, 16'd1, t1, 50, 1'b1);

        // T5: reset after five accepted pixels, then a clean restart
        px.delete();
        for (int i = 0; i < 16; i++) px.push_back(24'($urandom));
        begin_frame(16'd4, 16'd4, px);
        feed(px, 5, 100, 1'b0, k);
        check("t5_taken", 32'(k), 32'd5);
        rst = 1'b1;
        mon_en = 1'b0;
        tick();
        check_reset_outputs("t5_rst");
        rst = 1'b0;
        tick();
        run_frame(16'd2, 16'd1, t1, 100, 1'b0);

        // Randomized frames
        for (int r = 0; r < 25; r++) begin
            w = 16'($urandom_range(5));
            h = 16'($urandom_range(4));
            px.delete();
            for (int i = 0; i < 32'(w) * 32'(h); i++) px.push_back(24'($urandom));
            run_frame(w, h, px, int'($urandom_range(100, 30)),
                      (px.size() > 0) && ($urandom_range(1) == 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
